// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the controller's
// D_MEM request interface. Accepts one request in IDLE, waits LATENCY
// cycles, then answers with a single-cycle ACK (plus ERR when the word
// index is outside the implemented range).
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   D_MEM_CSN       active-low request strobe (sampled only in IDLE)
//   D_MEM_ADDR      byte address, bits [1:0] ignored
//   D_MEM_WEN       0 = write, 1 = read
//   D_MEM_BE        byte lane enables for writes
//   D_MEM_DOUT      write data, lane aligned
//   D_MEM_DI        registered read data, 0 outside a read response
//   D_MEM_ACK       one-cycle completion pulse
//   D_MEM_BUSY      high from the cycle after accept through the ACK cycle
//   D_MEM_ERR       high with ACK for an out-of-range request
//
// RAM contents are not reset; the surrounding top/bench loads the image.

// One byte lane of the word RAM: synchronous write, asynchronous read.
module dmem_lane #(
  parameter int IW = 10
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [7:0]    wdata,
  input  logic [IW-1:0] ridx,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**IW];

  always_ff @(posedge CLK)
    if (we) mem[widx] <= wdata;

  assign rdata = mem[ridx];
endmodule

module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int LATENCY     = 2,
  parameter int DEPTH_LIMIT = 2**(ADDR_W-2)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              D_MEM_CSN,
  input  logic [ADDR_W-1:0] D_MEM_ADDR,
  input  logic              D_MEM_WEN,
  input  logic [3:0]        D_MEM_BE,
  input  logic [31:0]       D_MEM_DOUT,
  output logic [31:0]       D_MEM_DI,
  output logic              D_MEM_ACK,
  output logic              D_MEM_BUSY,
  output logic              D_MEM_ERR
);
  localparam int            NUM_LANES = 4;
  localparam int            IW        = ADDR_W - 2;
  localparam logic [3:0]    LAT4      = LATENCY[3:0];
  localparam logic [IW:0]   LIMIT     = DEPTH_LIMIT[IW:0];

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_lat_chk
      $error("dmem_responder: LATENCY must be 0..15 (4-bit wait counter)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                         state, nxt;
  logic [3:0]                     cnt;
  logic [IW-1:0]                  idx_q;
  logic                           wen_q, oor_q;
  logic [NUM_LANES-1:0]           be_q;
  logic [NUM_LANES-1:0][7:0]      dout_q;
  logic [NUM_LANES-1:0][7:0]      rd_word;

  // Address bits [1:0] are don't-care for a word-organised memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^D_MEM_ADDR[1:0];

  // In IDLE the request is being accepted this edge, so use the live
  // inputs; otherwise use what was latched. This lets LATENCY=0 go straight
  // from accept into RESP with correct data/ERR.
  logic          accept;
  logic [IW-1:0] cur_idx;
  logic          cur_wen, cur_oor;

  assign accept  = (state == IDLE) && !D_MEM_CSN;
  assign cur_idx = (state == IDLE) ? D_MEM_ADDR[ADDR_W-1:2] : idx_q;
  assign cur_wen = (state == IDLE) ? D_MEM_WEN : wen_q;
  assign cur_oor = (state == IDLE) ? ({1'b0, D_MEM_ADDR[ADDR_W-1:2]} >= LIMIT) : oor_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!D_MEM_CSN) nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      D_MEM_DI   <= '0;
      D_MEM_ACK  <= 1'b0;
      D_MEM_BUSY <= 1'b0;
      D_MEM_ERR  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        idx_q  <= D_MEM_ADDR[ADDR_W-1:2];
        wen_q  <= D_MEM_WEN;
        be_q   <= D_MEM_BE;
        dout_q <= D_MEM_DOUT;
        oor_q  <= cur_oor;
        cnt    <= LAT4;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      D_MEM_ACK  <= (nxt == RESP);
      D_MEM_BUSY <= (nxt != IDLE);
      D_MEM_ERR  <= (nxt == RESP) && cur_oor;
      D_MEM_DI   <= ((nxt == RESP) && cur_wen && !cur_oor) ? rd_word : '0;
    end
  end

  // Writes commit on the RESP->IDLE edge; a reset on that edge aborts them.
  logic wr_commit;
  assign wr_commit = !RST && (state == RESP) && !wen_q && !oor_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dmem_lane #(.IW(IW)) u_lane (
      .CLK   (CLK),
      .we    (wr_commit && be_q[i]),
      .widx  (idx_q),
      .wdata (dout_q[i]),
      .ridx  (cur_idx),
      .rdata (rd_word[i])
    );
  end
endmodule
